// File: rtl/div_pkg.sv
// ============================================================================
// Module   : div_pkg
// Purpose  : Shared definitions for the multicycle divider: FSM state type
//            and the default datapath width. Imported by the control unit,
//            the divider and its bench.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package div_pkg;

  localparam int DIV_WIDTH = 32;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    FIX  = 2'd2,
    ZERO = 2'd3
  } div_state_t;

endpackage : div_pkg

`default_nettype wire

// File: rtl/div_restore_step.sv
// ============================================================================
// Module   : div_restore_step
// Purpose  : One combinational restoring-division iteration. The pair
//            {rem,q} is shifted left one bit, the divisor is trial-subtracted
//            from the new partial remainder, and the subtraction is kept only
//            when it does not go negative. The new quotient bit enters q[0].
// Ports    : rem_i  - current partial remainder
//            q_i    - current quotient / dividend shift register
//            div_i  - divisor magnitude
//            rem_o  - next partial remainder
//            q_o    - next quotient shift register
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_restore_step
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] q_i,
  input  logic [WIDTH-1:0] div_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] q_o
);

  // The remainder stays below the divisor (at most 2^(WIDTH-1)), so the
  // shifted remainder always fits WIDTH bits and bit WIDTH of the trial
  // difference is a reliable borrow/sign flag.
  logic [WIDTH:0] w_rem_sh;
  logic [WIDTH:0] w_trial;

  assign w_rem_sh = {rem_i, q_i[WIDTH-1]};
  assign w_trial  = w_rem_sh - {1'b0, div_i};

  assign rem_o = w_trial[WIDTH] ? w_rem_sh[WIDTH-1:0] : w_trial[WIDTH-1:0];
  assign q_o   = {q_i[WIDTH-2:0], ~w_trial[WIDTH]};

endmodule : div_restore_step

`default_nettype wire

// File: rtl/div_unit.sv
// ============================================================================
// Module   : div_unit
// Purpose  : Multicycle signed restoring divider (one quotient bit per clock)
//            for the MIPS multicycle datapath. Quotient goes to LO, remainder
//            to HI. Division by zero is flagged instead of computed.
// Ports    : clk       - clock, rising edge
//            reset     - asynchronous active-low reset
//            start     - divide request, honoured only when idle
//            dividend  - rs operand, sampled with start
//            divisor   - rt operand, sampled with start
//            unsigned_op - (DIV_UNIT_DIVU_EN only) divu when 1
//            busy      - operation in progress, through the done cycle
//            done      - one-cycle pulse, hi/lo valid
//            div_zero  - one-cycle pulse on divisor == 0
//            hi / lo   - remainder / quotient registers
// Config   : `define DIV_UNIT_DIVU_EN to add the unsigned_op port (divu).
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_unit
  import div_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
`ifdef DIV_UNIT_DIVU_EN
  input  logic             unsigned_op,
`endif
  output logic             busy,
  output logic             done,
  output logic             div_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  div_state_t       state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] div_q, div_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             neg_quo_q, neg_quo_d;
  logic             neg_rem_q, neg_rem_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic             dz_q, dz_d;

  logic [WIDTH-1:0] w_step_rem;
  logic [WIDTH-1:0] w_step_quo;
  logic             w_signed;
  logic [WIDTH-1:0] w_abs_dvd;
  logic [WIDTH-1:0] w_abs_dvs;

`ifdef DIV_UNIT_DIVU_EN
  assign w_signed = ~unsigned_op;
`else
  assign w_signed = 1'b1;
`endif

  // Negating 0x80000000 yields 0x80000000, which read unsigned is exactly
  // 2^31, so the most negative operand needs no special case.
  assign w_abs_dvd = (w_signed && dividend[WIDTH-1]) ? -dividend : dividend;
  assign w_abs_dvs = (w_signed && divisor[WIDTH-1])  ? -divisor  : divisor;

  div_restore_step #(
    .WIDTH (WIDTH)
  ) u_step (
    .rem_i (rem_q),
    .q_i   (quo_q),
    .div_i (div_q),
    .rem_o (w_step_rem),
    .q_o   (w_step_quo)
  );

  always_comb begin
    state_d   = state_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    div_d     = div_q;
    cnt_d     = cnt_q;
    neg_quo_d = neg_quo_q;
    neg_rem_d = neg_rem_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    busy_d    = 1'b0;
    done_d    = 1'b0;
    dz_d      = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          busy_d = 1'b1;
          if (divisor == '0) begin
            state_d = ZERO;
          end else begin
            quo_d     = w_abs_dvd;
            div_d     = w_abs_dvs;
            rem_d     = '0;
            neg_quo_d = w_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            neg_rem_d = w_signed & dividend[WIDTH-1];
            cnt_d     = '0;
            state_d   = RUN;
          end
        end
      end
      RUN: begin
        busy_d = 1'b1;
        rem_d  = w_step_rem;
        quo_d  = w_step_quo;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        // busy, done and the new hi/lo all become visible on the same edge.
        busy_d  = 1'b1;
        done_d  = 1'b1;
        lo_d    = neg_quo_q ? -quo_q : quo_q;
        hi_d    = neg_rem_q ? -rem_q : rem_q;
        state_d = IDLE;
      end
      ZERO: begin
        busy_d  = 1'b1;
        dz_d    = 1'b1;
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      rem_q     <= '0;
      quo_q     <= '0;
      div_q     <= '0;
      cnt_q     <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      rem_q     <= rem_d;
      quo_q     <= quo_d;
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      neg_quo_q <= neg_quo_d;
      neg_rem_q <= neg_rem_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      dz_q      <= dz_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign div_zero = dz_q;
  assign hi       = hi_q;
  assign lo       = lo_q;

endmodule : div_unit

`default_nettype wire

// File: tb/tb_div_unit.sv
// ============================================================================
// Module   : tb_div_unit
// Purpose  : Self-checking bench for div_unit: reset state, directed vector
//            table, mid-operation reset, ignored start, random operands
//            against an arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_div_unit;
  import div_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [31:0] dividend;
  logic [31:0] divisor;
`ifdef DIV_UNIT_DIVU_EN
  logic        unsigned_op;
`endif
  logic        busy;
  logic        done;
  logic        div_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int n_checks = 0;
  int n_fail   = 0;

  logic [31:0] model_lo = '0;
  logic [31:0] model_hi = '0;

  typedef struct {
    string       name;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] lo;
    logic [31:0] hi;
    bit          zero;
  } vec_t;

  vec_t vecs[12];

  div_unit #(.WIDTH(DIV_WIDTH)) dut (
    .clk      (clk),
    .reset    (reset),
    .start    (start),
    .dividend (dividend),
    .divisor  (divisor),
`ifdef DIV_UNIT_DIVU_EN
    .unsigned_op (unsigned_op),
`endif
    .busy     (busy),
    .done     (done),
    .div_zero (div_zero),
    .hi       (hi),
    .lo       (lo)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Reference: 64-bit signed arithmetic truncates toward zero and gives the
  // remainder the dividend's sign; low 32 bits give the MIPS wrap result.
  task automatic model(input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    if (b != 0) begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      q  = sa / sb;
      r  = sa % sb;
      model_lo = q[31:0];
      model_hi = r[31:0];
    end
  endtask

  task automatic wait_result(input int inject_at, output int lat, output bit busy_ok,
                             output bit saw_zero, output bit saw_done);
    lat = -1; busy_ok = 1'b1; saw_zero = 1'b0; saw_done = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      if (k - 1 == inject_at) begin
        start = 1'b1; dividend = 32'd9; divisor = 32'd3;
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      if (!busy) busy_ok = 1'b0;
      if (done) saw_done = 1'b1;
      if (div_zero) saw_zero = 1'b1;
      if (done || div_zero) begin
        lat = k;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic do_op(input string nm, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] elo, input logic [31:0] ehi, input bit ezero,
                       input int inject_at);
    int lat; bit bok, sz, sd;
    start = 1'b1; dividend = a; divisor = b;
    @(posedge clk); #1;
    dividend = $urandom; divisor = $urandom;
    wait_result(inject_at, lat, bok, sz, sd);
    chk({nm, " latency"}, lat, ezero ? 32'd1 : 32'd33);
    chk({nm, " busy"}, {31'd0, bok}, 32'd1);
    chk({nm, " div_zero"}, {31'd0, sz}, {31'd0, ezero});
    chk({nm, " done"}, {31'd0, sd}, {31'd0, ~ezero});
    chk({nm, " lo"}, lo, elo);
    chk({nm, " hi"}, hi, ehi);
  endtask

  initial begin
    vecs[0]  = '{"100/7 b2b",  32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
    vecs[1]  = '{"-100/7",     32'hFFFFFF9C,   32'd7,          32'hFFFFFFF2,   32'hFFFFFFFE,   1'b0};
    vecs[2]  = '{"100/-7",     32'd100,        32'hFFFFFFF9,   32'hFFFFFFF2,   32'd2,          1'b0};
    vecs[3]  = '{"-100/-7",    32'hFFFFFF9C,   32'hFFFFFFF9,   32'd14,         32'hFFFFFFFE,   1'b0};
    vecs[4]  = '{"ovf",        32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0};
    vecs[5]  = '{"0/5",        32'd0,          32'd5,          32'd0,          32'd0,          1'b0};
    vecs[6]  = '{"7/100",      32'd7,          32'd100,        32'd0,          32'd7,          1'b0};
    vecs[7]  = '{"-1/1",       32'hFFFFFFFF,   32'd1,          32'hFFFFFFFF,   32'd0,          1'b0};
    vecs[8]  = '{"min/2",      32'h80000000,   32'd2,          32'hC0000000,   32'd0,          1'b0};
    vecs[9]  = '{"max/min",    32'h7FFFFFFF,   32'h80000000,   32'd0,          32'h7FFFFFFF,   1'b0};
    vecs[10] = '{"min/0",      32'h80000000,   32'd0,          32'd0,          32'h7FFFFFFF,   1'b1};
    vecs[11] = '{"min/min",    32'h80000000,   32'h80000000,   32'd1,          32'd0,          1'b0};

    reset = 1'b0; start = 1'b0; dividend = '0; divisor = '0;
`ifdef DIV_UNIT_DIVU_EN
    unsigned_op = 1'b0;
`endif
    repeat (3) @(posedge clk);
    #1;
    chk("rst busy", {31'd0, busy}, 32'd0);
    chk("rst done", {31'd0, done}, 32'd0);
    chk("rst div_zero", {31'd0, div_zero}, 32'd0);
    chk("rst hi", hi, 32'd0);
    chk("rst lo", lo, 32'd0);
    reset = 1'b1;
    @(posedge clk); #1;

    // 100/7 then verify done is a single-cycle pulse
    do_op("100/7", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, -1);
    @(posedge clk); #1;
    chk("done pulse width", {31'd0, done}, 32'd0);
    chk("busy after done", {31'd0, busy}, 32'd0);

    // divide by zero keeps previous HI/LO
    do_op("5/0", 32'd5, 32'd0, 32'd14, 32'd2, 1'b1, -1);
    @(posedge clk); #1;
    chk("div_zero pulse width", {31'd0, div_zero}, 32'd0);

    // table, issued back-to-back: each start coincides with the previous done
    for (int i = 0; i < 12; i++)
      do_op(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].lo, vecs[i].hi, vecs[i].zero, -1);

    // reset mid-operation
    start = 1'b1; dividend = 32'd100; divisor = 32'd7;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    chk("midrst busy", {31'd0, busy}, 32'd0);
    chk("midrst hi", hi, 32'd0);
    chk("midrst lo", lo, 32'd0);
    @(posedge clk); #1;
    reset = 1'b1;
    begin
      bit sd = 1'b0;
      for (int k = 0; k < 40; k++) begin
        @(posedge clk); #1;
        if (done || busy) sd = 1'b1;
      end
      chk("midrst no done", {31'd0, sd}, 32'd0);
    end
    do_op("9/3 after rst", 32'd9, 32'd3, 32'd3, 32'd0, 1'b0, -1);

    // start during RUN is ignored
    do_op("ignored start", 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 4);
    @(posedge clk); #1;
    chk("ignored start idle", {31'd0, busy}, 32'd0);
    model_lo = 32'd14; model_hi = 32'd2;

`ifdef DIV_UNIT_DIVU_EN
    unsigned_op = 1'b1;
    do_op("divu", 32'hFFFFFFFF, 32'd2, 32'h7FFFFFFF, 32'd1, 1'b0, -1);
    unsigned_op = 1'b0;
    model_lo = 32'h7FFFFFFF; model_hi = 32'd1;
`endif

    // random operands against the arithmetic model
    for (int i = 0; i < 150; i++) begin
      logic [31:0] a, b;
      int sel;
      a   = $urandom;
      sel = $urandom_range(0, 9);
      case (sel)
        0:       b = 32'd0;
        1, 2, 3: b = $urandom_range(1, 20);
        4:       b = -$urandom_range(1, 20);
        5:       begin b = $urandom_range(1, 1000); a = $urandom_range(0, 5000); end
        default: b = $urandom;
      endcase
      model(a, b);
      do_op("random", a, b, model_lo, model_hi, (b == 32'd0), -1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule : tb_div_unit

`default_nettype wire

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multicycle signed 32-bit divider for the MIPS multicycle datapath.
- Acts as the responder to the control unit's divide handshake:
  - receives DivCtrl as start;
  - returns DivOut as done and divZero as div_zero;
  - writes quotient to LO and remainder to HI.
- Restoring algorithm: one quotient bit per clock, operands latched at start.

Parameters:
- WIDTH, 32, operand/result width in bits.
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived; do not override).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-low reset; clears all state when 0.
- start  input  1  request (DivCtrl); sampled only in IDLE.
- dividend  input  WIDTH  rs operand; sampled with start.
- divisor  input  WIDTH  rt operand; sampled with start.
- busy  output  1  high from the cycle after accepted start until done/div_zero cycle inclusive.
- done  output  1  one-cycle pulse (DivOut); hi/lo valid from this cycle.
- div_zero  output  1  one-cycle pulse (divZero) on divisor==0.
- hi  output  WIDTH  remainder register (HI).
- lo  output  WIDTH  quotient register (LO).

Behaviour:
- Reset (reset==0, any time, including mid-operation):
  - state=IDLE; busy, done, div_zero, hi, lo, counter, internal registers all 0.
  - An in-flight operation is abandoned; no done is produced.
- States: IDLE, RUN, FIX, ZERO.
- IDLE:
  - On start==1 with divisor==0: go to ZERO; operands not loaded.
  - On start==1 otherwise: latch |dividend| into quotient shift register, |divisor| into divisor register, partial remainder=0, sign_q=dividend[31]^divisor[31], sign_r=dividend[31], count=0; go to RUN.
- RUN (one restoring step per edge):
  - {rem,q} shifted left 1; trial = rem - div computed at WIDTH+1 bits.
  - Trial non-negative: rem=trial, q[0]=1. Otherwise rem unchanged, q[0]=0.
  - count increments; after the WIDTH-th step go to FIX.
- FIX:
  - lo = sign_q ? -q : q; hi = sign_r ? -rem : rem (two's complement, WIDTH bits, wrap).
  - done=1 for exactly this cycle's output; go to IDLE.
- ZERO: div_zero=1 for one cycle; hi/lo keep previous values; go to IDLE.
- Latency:
  - Start sampled at edge E0; done visible after edge E(WIDTH+1), i.e. 33 cycles for WIDTH=32.
  - div_zero visible after E1.
- start while not IDLE: ignored; operands may change freely during RUN.
- Overflow 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0 (natural wrap, no flag).
- Absolute value of 0x80000000 treated as unsigned 2^31 (correct in WIDTH bits).
- hi/lo change only in FIX or on reset.
- start and done in the same cycle: start accepted on the following edge (state already IDLE).

Optional Feature:
- DIV_UNIT_DIVU_EN defined:
  - Adds input port unsigned_op (1 bit), sampled with start.
  - When 1: no absolute value and no sign fix-up (sign_q=sign_r=0); implements MIPS divu.
- Undefined: port absent; all operations signed.

Decomposition:
- Package div_pkg:
  - state typedef div_state_t {IDLE, RUN, FIX, ZERO};
  - DIV_WIDTH=32 constant;
  - shared by control unit and bench.
- Sub-module div_restore_step (combinational):
  - inputs rem, q, div;
  - outputs next rem, next q;
  - a single restoring iteration, instantiated once in div_unit.

Test Plan:
- 100 / 7 -> done after 33 cycles; lo=14, hi=2; busy high throughout, done a single pulse.
- -100 / 7 -> lo=0xFFFFFFF2 (-14), hi=0xFFFFFFFE (-2); 100 / -7 -> lo=-14, hi=2.
- 0x80000000 / 0xFFFFFFFF -> lo=0x80000000, hi=0, done asserted, no div_zero.
- 5 / 0 after prior result lo=14, hi=2 -> div_zero one cycle after start, no done, lo=14, hi=2 retained.
- Start 100/7, pull reset low at cycle 10 -> busy=0, hi=lo=0, no done. Then 9/3 -> lo=3, hi=0.
- Start 100/7, assert start with 9/3 at cycle 5 -> ignored; result lo=14, hi=2.
- With DIV_UNIT_DIVU_EN: 0xFFFFFFFF / 2, unsigned_op=1 -> lo=0x7FFFFFFF, hi=1.
